// File: rtl/csa_resolve_reduce.sv
// csa_resolve_reduce: resolves a Montgomery carry-save pair (s0,s1) to binary one
// W-bit digit per enabled cycle (LSB first), then applies the single conditional
// subtraction of n so the result lies in [0, n).
// Optional feature macro: CSA_RESOLVE_SUB_EN
//   defined   -> result = (s0+s1) < n ? s0+s1 : s0+s1-n
//   undefined -> result = (s0+s1) mod 2^K; no diff register or borrow chain.
module csa_resolve_reduce #(
  parameter int unsigned K = 1027,
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         start,
  input  logic [K-1:0] s0,
  input  logic [K-1:0] s1,
  input  logic [K-1:0] n,
  output logic [K-1:0] result,
  output logic         busy,
  output logic         done
);

  localparam int unsigned D  = (K + W - 1) / W;
  localparam int unsigned DW = D * W;
  localparam int unsigned CW = (D > 1) ? $clog2(D) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic [DW-1:0]   a0_q, a0_d;
  logic [DW-1:0]   a1_q, a1_d;
  logic [DW-1:0]   sum_q, sum_d;
  logic [K-1:0]    result_d;
  logic            busy_d, done_d;

  // Per-digit adder outputs
  logic [W:0]      add_w;
  logic [W-1:0]    sum_dig;
  logic            carry_nx;
  logic [DW-1:0]   sum_shift;
  logic            last_dig;

`ifdef CSA_RESOLVE_SUB_EN
  logic [DW-1:0]   n_q, n_d;
  logic [DW-1:0]   dif_q, dif_d;
  logic            borrow_q, borrow_d;
  logic [W:0]      sub_w;
  logic [W-1:0]    dif_dig;
  logic            borrow_nx;
  logic [DW-1:0]   dif_shift;
`else
  logic            unused_n;
  assign unused_n = ^n;
`endif

  // Digit datapath: add the current digit pair, then chain the subtraction of n
  always_comb begin
    add_w     = (W+1)'(a0_q[W-1:0]) + (W+1)'(a1_q[W-1:0]) + (W+1)'(carry_q);
    sum_dig   = add_w[W-1:0];
    carry_nx  = add_w[W];
    // New digit enters at the top; the full value is ready on the last digit edge
    sum_shift = DW'({sum_dig, sum_q} >> W);
    last_dig  = (cnt_q == CW'(D - 1));
`ifdef CSA_RESOLVE_SUB_EN
    sub_w     = (W+1)'(sum_dig) - (W+1)'(n_q[W-1:0]) - (W+1)'(borrow_q);
    dif_dig   = sub_w[W-1:0];
    borrow_nx = sub_w[W];
    dif_shift = DW'({dif_dig, dif_q} >> W);
`endif
  end

  // Next-state and register-input logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a0_d     = a0_q;
    a1_d     = a1_q;
    sum_d    = sum_q;
    result_d = result;
    busy_d   = busy;
    done_d   = done;
`ifdef CSA_RESOLVE_SUB_EN
    n_d      = n_q;
    dif_d    = dif_q;
    borrow_d = borrow_q;
`endif
    if (ce) begin
      done_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            cnt_d   = '0;
            carry_d = 1'b0;
            a0_d    = DW'(s0);
            a1_d    = DW'(s1);
            sum_d   = '0;
            busy_d  = 1'b1;
`ifdef CSA_RESOLVE_SUB_EN
            n_d      = DW'(n);
            dif_d    = '0;
            borrow_d = 1'b0;
`endif
          end
        end
        RUN: begin
          cnt_d   = cnt_q + CW'(1);
          carry_d = carry_nx;
          a0_d    = DW'(a0_q >> W);
          a1_d    = DW'(a1_q >> W);
          sum_d   = sum_shift;
`ifdef CSA_RESOLVE_SUB_EN
          n_d      = DW'(n_q >> W);
          dif_d    = dif_shift;
          borrow_d = borrow_nx;
`endif
          if (last_dig) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`ifdef CSA_RESOLVE_SUB_EN
            // Final borrow set means sum < n, so keep the unreduced sum
            result_d = borrow_nx ? sum_shift[K-1:0] : dif_shift[K-1:0];
`else
            result_d = sum_shift[K-1:0];
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a0_q     <= '0;
      a1_q     <= '0;
      sum_q    <= '0;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef CSA_RESOLVE_SUB_EN
      n_q      <= '0;
      dif_q    <= '0;
      borrow_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a0_q     <= a0_d;
      a1_q     <= a1_d;
      sum_q    <= sum_d;
      result   <= result_d;
      busy     <= busy_d;
      done     <= done_d;
`ifdef CSA_RESOLVE_SUB_EN
      n_q      <= n_d;
      dif_q    <= dif_d;
      borrow_q <= borrow_d;
`endif
    end
  end

endmodule
